// File: rtl/array_deser_pkg.sv
// Shared types and sizing helpers for the array_deser stream-to-array deserializer.
package array_deser_pkg;

   // FILL collects words; HOLD parks a finished frame while the output slot is still occupied.
   typedef enum logic {FILL, HOLD} array_deser_state_t;

   // Width of the word counter that indexes 0..M-1, never narrower than one bit.
   function automatic int cnt_width(input int m);
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

   // Width of a frame-length field that must hold 1..M, never narrower than one bit.
   function automatic int len_width(input int m);
      return (m <= 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/array_deser_if.sv
// Handshake bundle for array_deser: word stream in, M-element frame out.
// Optional macro ARRAY_DESER_LAST_EN adds in_last (early frame close) and out_len.
interface array_deser_if #(
   parameter int N = 2,
   parameter int M = 2
) ();
   import array_deser_pkg::*;

   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data [M];
   logic         out_valid;
   logic         out_ready;

`ifdef ARRAY_DESER_LAST_EN
   logic                       in_last;
   logic [len_width(M)-1:0]    out_len;

   // Producer of words and consumer of frames.
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_len
   );

   // The deserializer itself.
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_len
   );
`else
   // Producer of words and consumer of frames.
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // The deserializer itself.
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
`endif

endinterface

// File: rtl/array_deser.sv
// Stream-to-array deserializer: gathers M consecutive N-bit words into one frame
// and offers it on an unpacked-array output with its own valid/ready handshake.
// Element 0 of the frame is the first word received.
// Optional macro ARRAY_DESER_LAST_EN: in_last closes a frame early (unfilled
// elements read as zero) and out_len reports how many words the frame carries.
module array_deser
   import array_deser_pkg::*;
#(
   parameter int N = 2,
   parameter int M = 2
) (
   input logic           clock,
   input logic           reset,
   array_deser_if.slave  bus
);

   localparam int             CntW    = cnt_width(M);
   localparam logic [CntW-1:0] LastIdx = CntW'(M - 1);

`ifdef ARRAY_DESER_LAST_EN
   localparam int LenW = len_width(M);
`endif

   array_deser_state_t r_state;
   logic [CntW-1:0]    r_cnt;
   logic [N-1:0]       r_buf     [M];
   logic [N-1:0]       r_outData [M];
   logic               r_outValid;

   logic [N-1:0]       w_frame   [M];
   logic               w_frameDone;

`ifdef ARRAY_DESER_LAST_EN
   logic [LenW-1:0]    r_outLen;
   logic [LenW-1:0]    r_holdLen;
   logic [LenW-1:0]    w_len;

   // A frame ends on the M-th word or on any accepted word flagged as last.
   assign w_frameDone = (r_cnt == LastIdx) || bus.in_last;
   assign w_len       = LenW'(r_cnt) + LenW'(1);
   assign bus.out_len = r_outLen;
`else
   // A frame ends on the M-th word.
   assign w_frameDone = (r_cnt == LastIdx);
`endif

   // in_ready depends only on registered state, so out_ready never ripples back to the producer.
   assign bus.in_ready  = (r_state == FILL);
   assign bus.out_valid = r_outValid;
   assign bus.out_data  = r_outData;

   // The frame being closed this cycle: collected words, the incoming word at the current slot, zeros beyond it.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         if (i < int'(r_cnt)) begin
            w_frame[i] = r_buf[i];
         end else if (i == int'(r_cnt)) begin
            w_frame[i] = bus.in_data;
         end else begin
            w_frame[i] = '0;
         end
      end
   end

   // Collection FSM and output slot: a finished frame goes straight to the output if the slot is free, otherwise it parks in the buffer (HOLD) until the slot drains.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= FILL;
         r_cnt      <= '0;
         r_outValid <= 1'b0;
         for (int i = 0; i < M; i++) begin
            r_buf[i]     <= '0;
            r_outData[i] <= '0;
         end
`ifdef ARRAY_DESER_LAST_EN
         r_outLen  <= '0;
         r_holdLen <= '0;
`endif
      end else begin
         if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
         end
         case (r_state)
            FILL: begin
               if (bus.in_valid) begin
                  if (w_frameDone) begin
                     r_cnt <= '0;
                     if (!r_outValid || bus.out_ready) begin
                        r_outData  <= w_frame;
                        r_outValid <= 1'b1;
`ifdef ARRAY_DESER_LAST_EN
                        r_outLen   <= w_len;
`endif
                     end else begin
                        r_buf   <= w_frame;
                        r_state <= HOLD;
`ifdef ARRAY_DESER_LAST_EN
                        r_holdLen <= w_len;
`endif
                     end
                  end else begin
                     r_buf[r_cnt] <= bus.in_data;
                     r_cnt        <= r_cnt + CntW'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  r_outData  <= r_buf;
                  r_outValid <= 1'b1;
                  r_state    <= FILL;
`ifdef ARRAY_DESER_LAST_EN
                  r_outLen   <= r_holdLen;
`endif
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_array_deser.sv
// Testbench for array_deser: an M=4 instance checked every cycle against a
// frame-queue reference model, plus a short directed run on an M=1 instance.
module tb_array_deser;

   localparam int N = 8;
   localparam int M = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   array_deser_if #(.N(N), .M(M)) bus4 ();
   array_deser_if #(.N(N), .M(1)) bus1 ();

   array_deser #(.N(N), .M(M)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
   array_deser #(.N(N), .M(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

   int assertCount = 0;
   int failCount   = 0;

   // Reference model: words of the frame being gathered, and completed frames not yet
   // consumed downstream. The block can own at most two finished frames (one offered,
   // one parked), so it accepts words only while fewer than two are outstanding.
   logic [N-1:0]   partialQ [$];
   logic [N*M-1:0] frameQ   [$];
   int             lenQ     [$];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [N*M-1:0] dutFrame();
      logic [N*M-1:0] f;
      for (int i = 0; i < M; i++) f[N*(M-1-i) +: N] = bus4.out_data[i];
      return f;
   endfunction

   task automatic modelStep(input logic v, input logic [N-1:0] d, input logic l, input logic rdy);
      bit             consume;
      bit             accept;
      logic [N*M-1:0] f;
      logic [N*M-1:0] dropF;
      int             dropL;
      consume = (frameQ.size() > 0) && rdy;
      accept  = v && (frameQ.size() < 2);
      if (consume) begin
         dropF = frameQ.pop_front();
         dropL = lenQ.pop_front();
      end
      if (accept) begin
         partialQ.push_back(d);
         if (partialQ.size() == M || l) begin
            f = '0;
            for (int i = 0; i < partialQ.size(); i++) f[N*(M-1-i) +: N] = partialQ[i];
            frameQ.push_back(f);
            lenQ.push_back(partialQ.size());
            partialQ.delete();
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("in_ready", 64'(bus4.in_ready), 64'(frameQ.size() < 2));
      checkOutput("out_valid", 64'(bus4.out_valid), 64'(frameQ.size() > 0));
      if (frameQ.size() > 0) begin
         checkOutput("out_data", 64'(dutFrame()), 64'(frameQ[0]));
`ifdef ARRAY_DESER_LAST_EN
         checkOutput("out_len", 64'(bus4.out_len), 64'(lenQ[0]));
`endif
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic l, input logic rdy);
      bus4.in_valid  = v;
      bus4.in_data   = d;
`ifdef ARRAY_DESER_LAST_EN
      bus4.in_last   = l;
`endif
      bus4.out_ready = rdy;
      @(posedge clock);
      modelStep(v, d, l, rdy);
      #1;
      checkModel();
   endtask

   task automatic stepM1(input logic v, input logic [N-1:0] d, input logic rdy);
      bus1.in_valid  = v;
      bus1.in_data   = d;
      bus1.out_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      bus4.in_valid  = 1'b0;
      bus4.in_data   = '0;
      bus4.out_ready = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.out_ready = 1'b0;
`ifdef ARRAY_DESER_LAST_EN
      bus4.in_last   = 1'b0;
      bus1.in_last   = 1'b0;
`endif
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      partialQ.delete();
      frameQ.delete();
      lenQ.delete();
      checkOutput("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(bus4.in_ready), 64'd1);
      checkOutput("rst_out_data", 64'(dutFrame()), 64'd0);
      checkOutput("rst_m1_out_data", 64'(bus1.out_data[0]), 64'd0);
`ifdef ARRAY_DESER_LAST_EN
      checkOutput("rst_out_len", 64'(bus4.out_len), 64'd0);
`endif
   endtask

   // Main sequence: directed scenarios, randomized traffic, then the M=1 instance.
   initial begin
      int frames;
      int stalls;
      logic v;
      logic rdy;
      logic l;

      resetDut();

      // Plain frame with an always-ready consumer.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
      checkOutput("frame_a_valid", 64'(bus4.out_valid), 64'd1);
      checkOutput("frame_a_data", 64'(dutFrame()), 64'h11223344);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("frame_a_drop", 64'(bus4.out_valid), 64'd0);

      // Consumer stalled: first frame held on the output, second parked internally.
      for (int w = 1; w <= 8; w++) begin
         applyStimulus(1'b1, 8'(w), 1'b0, 1'b0);
         if (w == 4) checkOutput("stall_first", 64'(dutFrame()), 64'h01020304);
      end
      checkOutput("stall_in_ready", 64'(bus4.in_ready), 64'd0);
      checkOutput("stall_held", 64'(dutFrame()), 64'h01020304);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("stall_second", 64'(dutFrame()), 64'h05060708);
      checkOutput("stall_ready_back", 64'(bus4.in_ready), 64'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("stall_drained", 64'(bus4.out_valid), 64'd0);

      // Full-rate streaming: three frames in twelve cycles with no input stall.
      frames = 0;
      stalls = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, 8'(8'h30 + c), 1'b0, 1'b1);
         if (bus4.out_valid) frames++;
         if (!bus4.in_ready) stalls++;
      end
      checkOutput("stream_frames", 64'(frames), 64'd3);
      checkOutput("stream_stalls", 64'(stalls), 64'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of a frame discards the partial words.
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
      resetDut();
      for (int w = 1; w <= 4; w++) applyStimulus(1'b1, 8'(w), 1'b0, 1'b1);
      checkOutput("rst_frame", 64'(dutFrame()), 64'h01020304);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef ARRAY_DESER_LAST_EN
      // Short frame closed by in_last on the second word.
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b1);
      checkOutput("last_data", 64'(dutFrame()), 64'h10200000);
      checkOutput("last_len", 64'(bus4.out_len), 64'd2);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif

      // Randomized traffic with a reset dropped in halfway.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) resetDut();
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         l   = 1'b0;
`ifdef ARRAY_DESER_LAST_EN
         l   = ($urandom_range(0, 4) == 0);
`endif
         applyStimulus(v, 8'($urandom), l, rdy);
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Single-element frames on the M=1 instance.
      resetDut();
      stepM1(1'b1, 8'h5A, 1'b1);
      checkOutput("m1_first_valid", 64'(bus1.out_valid), 64'd1);
      checkOutput("m1_first_data", 64'(bus1.out_data[0]), 64'h5A);
      stepM1(1'b1, 8'hA5, 1'b1);
      checkOutput("m1_second_data", 64'(bus1.out_data[0]), 64'hA5);
      checkOutput("m1_second_ready", 64'(bus1.in_ready), 64'd1);
      stepM1(1'b0, 8'h00, 1'b0);
      checkOutput("m1_hold_valid", 64'(bus1.out_valid), 64'd1);
      checkOutput("m1_hold_data", 64'(bus1.out_data[0]), 64'hA5);
      stepM1(1'b1, 8'h3C, 1'b0);
      checkOutput("m1_park_ready", 64'(bus1.in_ready), 64'd0);
      checkOutput("m1_park_data", 64'(bus1.out_data[0]), 64'hA5);
      stepM1(1'b1, 8'hFF, 1'b1);
      checkOutput("m1_release_data", 64'(bus1.out_data[0]), 64'h3C);
      checkOutput("m1_release_ready", 64'(bus1.in_ready), 64'd1);
      stepM1(1'b0, 8'h00, 1'b1);
      checkOutput("m1_drained", 64'(bus1.out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
